wb_buffer_stage: RTL and testbench
==================================

WB_BUFFER_STAGE -- requirements
Module: wb_buffer_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32: signed writeback data width.
REQ-002 Parameter REG_ADDR_WIDTH, default 4: destination register address width.
REQ-003 Parameter CTRL_WIDTH, default 6: opcode width.
REQ-004 Parameter DEPTH, default 4, power of two, 2..16: write-buffer entries.
REQ-005 Parameter ZERO_REG, default 1: when 1, writes to address 0 are discarded.
REQ-006 Clocking and reset SHALL be: one clock, clk_in; reset RST, asynchronous, active-low.
REQ-007 clk_in  in  1  clock, all state on rising edge.
REQ-008 RST  in  1  asynchronous active-low reset.
REQ-009 in_valid  in  1  upstream offers an instruction result this cycle.
REQ-010 in_ready  out  1  stage can accept; equals buffer-not-full.
REQ-011 ctrl_in  in  CTRL_WIDTH  opcode of offered result.
REQ-012 data  in  DATA_WIDTH  signed result value.
REQ-013 addr  in  REG_ADDR_WIDTH  destination register.
REQ-014 wr_ready  in  1  register file accepts a write this cycle.
REQ-015 en_out  out  1  register write strobe (buffer head valid).
REQ-016 data_out / addr_out  out  DATA_WIDTH / REG_ADDR_WIDTH  buffer head value and address.
REQ-017 hz_addr  in  REG_ADDR_WIDTH  hazard/forward query address.
REQ-018 hz_pending  out  1  a buffered write to hz_addr exists.
REQ-019 hz_data  out  DATA_WIDTH  data of youngest buffered write to hz_addr, 0 if none.
REQ-020 wr_count  out  16  committed-write counter.

Function
REQ-021 Accept = in_valid & in_ready; write-class opcodes SHALL be LW, ADD, SUB, MUL, DIV, AND, OR, NOT; all others not write-class.
REQ-022 Accepted write-class entry with valid address (addr!=0 or ZERO_REG=0) SHALL be pushed to the FIFO; other accepted entries SHALL be discarded with no side effect.
REQ-023 Pushed entry SHALL appear at the head no earlier than the cycle after acceptance (latency 1 when buffer empty).
REQ-024 en_out SHALL equal head-valid; data_out/addr_out SHALL show head entry; when empty en_out=0, data_out=0, addr_out=0.
REQ-025 Pop SHALL occur on en_out & wr_ready; wr_count increments by 1 per pop, wrapping 0xFFFF->0.
REQ-026 in_ready SHALL depend only on occupancy (no combinational path from wr_ready or in_valid).
REQ-027 Simultaneous push and pop SHALL keep occupancy unchanged; full with pop SHALL still hold in_ready=0 that cycle.
REQ-028 Pointers SHALL wrap modulo DEPTH; occupancy counter is clog2(DEPTH)+1 bits.
REQ-029 hz_pending/hz_data SHALL be combinational over valid entries; youngest (most recently pushed) match wins; an entry popping this cycle still counts.
REQ-030 An entry being accepted in the current cycle SHALL NOT be visible on hz_* until the next cycle.

Reset
REQ-031 RST low SHALL immediately clear occupancy, pointers, wr_count; en_out=0, data_out=0, addr_out=0, hz_pending=0, hz_data=0, in_ready=0 while RST low.
REQ-032 Reset mid-operation SHALL drop all buffered entries without issuing writes; in_ready=1 first cycle after release.

Structure
REQ-033 Write-class opcode constants SHALL come from the shared processor parameter include; the write-class decode function SHALL be defined there for reuse by hazard logic elsewhere.
REQ-034 FIFO storage with pointers SHALL be one sub-module, wb_fifo, exposing entry arrays for the hazard search.

Verification
REQ-035 Empty buffer, ADD addr=3 data=-5, wr_ready=1 -> next cycle en_out=1, addr_out=3, data_out=-5; following cycle en_out=0, wr_count=1.
REQ-036 wr_ready=0, push 4 writes (DEPTH=4) -> in_ready=0 after 4th; 5th offer not accepted; release wr_ready -> 4 writes in order, wr_count=4.
REQ-037 Push ADD addr=0 (ZERO_REG=1) and branch opcode addr=2 -> both accepted, en_out never asserted, wr_count unchanged.
REQ-038 Buffer SUB r5=7 then MUL r5=9, wr_ready=0, hz_addr=5 -> hz_pending=1, hz_data=9; hz_addr=6 -> hz_pending=0, hz_data=0.
REQ-039 Full buffer, simultaneous pop and offer -> offer refused, occupancy 3 next cycle, in_ready=1.
REQ-040 Assert RST with 3 entries buffered, wr_ready=1 -> en_out=0 immediately, no further writes, wr_count=0 after release.

Source files
------------

// File: rtl/wb_buffer_stage_pkg.sv
// wb_buffer_stage_pkg: shared processor opcode constants and the write-class decode
package wb_buffer_stage_pkg;
    localparam logic [15:0] OP_LW  = 16'd1;
    localparam logic [15:0] OP_ADD = 16'd2;
    localparam logic [15:0] OP_SUB = 16'd3;
    localparam logic [15:0] OP_MUL = 16'd4;
    localparam logic [15:0] OP_DIV = 16'd5;
    localparam logic [15:0] OP_AND = 16'd6;
    localparam logic [15:0] OP_OR  = 16'd7;
    localparam logic [15:0] OP_NOT = 16'd8;

    function automatic logic is_write_class(input logic [15:0] op);
        return op inside {OP_LW, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_NOT};
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular write-buffer storage; entry arrays are exposed for the hazard search
module wb_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                        clk_in,
    input  logic                        RST,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic [REG_ADDR_WIDTH-1:0]   push_addr,
    output logic [$clog2(DEPTH)-1:0]    rd_ptr,
    output logic [$clog2(DEPTH):0]      count,
    output logic [DATA_WIDTH-1:0]       entry_data [DEPTH],
    output logic [REG_ADDR_WIDTH-1:0]   entry_addr [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr;

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload needs no reset: only slots inside the occupancy window are ever read
    always_ff @(posedge clk_in) begin
        if (push) begin
            entry_data[wr_ptr] <= push_data;
            entry_addr[wr_ptr] <= push_addr;
        end
    end
endmodule

// File: rtl/wb_buffer_stage.sv
// wb_buffer_stage: writeback buffer decoupling result commit from register-file write
// acceptance, with a youngest-match forwarding lookup over buffered writes.
module wb_buffer_stage
    import wb_buffer_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 4,
    parameter int CTRL_WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int ZERO_REG = 1
) (
    input  logic                        clk_in,
    input  logic                        RST,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CTRL_WIDTH-1:0]       ctrl_in,
    input  logic [DATA_WIDTH-1:0]       data,
    input  logic [REG_ADDR_WIDTH-1:0]   addr,
    input  logic                        wr_ready,
    output logic                        en_out,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic [REG_ADDR_WIDTH-1:0]   addr_out,
    input  logic [REG_ADDR_WIDTH-1:0]   hz_addr,
    output logic                        hz_pending,
    output logic [DATA_WIDTH-1:0]       hz_data,
    output logic [15:0]                 wr_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic                      push;
    logic                      pop;
    logic [PW-1:0]             rd_ptr;
    logic [CW-1:0]             count;
    logic [DATA_WIDTH-1:0]     entry_data [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] entry_addr [DEPTH];

    assign in_ready = RST && count != CW'(DEPTH);
    assign push     = in_valid && in_ready && is_write_class(16'(ctrl_in))
                      && (ZERO_REG == 0 || addr != '0);
    assign en_out   = count != '0;
    assign pop      = en_out && wr_ready;
    assign data_out = en_out ? entry_data[rd_ptr] : '0;
    assign addr_out = en_out ? entry_addr[rd_ptr] : '0;

    wb_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_in(clk_in),
        .RST(RST),
        .push(push),
        .pop(pop),
        .push_data(data),
        .push_addr(addr),
        .rd_ptr(rd_ptr),
        .count(count),
        .entry_data(entry_data),
        .entry_addr(entry_addr)
    );

    // Walk oldest to youngest so the last match left standing is the youngest
    always_comb begin
        hz_pending = 1'b0;
        hz_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && entry_addr[rd_ptr + PW'(i)] == hz_addr) begin
                hz_pending = 1'b1;
                hz_data = entry_data[rd_ptr + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST)
            wr_count <= '0;
        else if (pop)
            wr_count <= wr_count + 16'd1;
    end
endmodule

// File: tb/tb_wb_buffer_stage.sv
// tb_wb_buffer_stage: table-driven directed checks of wb_buffer_stage plus a mid-run reset sequence
module tb_wb_buffer_stage;
    localparam logic [5:0] NOP = 6'd0, LW = 6'd1, ADD = 6'd2, SUB = 6'd3, MUL = 6'd4,
                           DIV = 6'd5, AND = 6'd6, OR = 6'd7, NOT = 6'd8, BEQ = 6'd9;

    logic        clk_in = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  ctrl_in;
    logic [31:0] data;
    logic [3:0]  addr;
    logic        wr_ready;
    logic        en_out;
    logic [31:0] data_out;
    logic [3:0]  addr_out;
    logic [3:0]  hz_addr;
    logic        hz_pending;
    logic [31:0] hz_data;
    logic [15:0] wr_count;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    wb_buffer_stage dut (
        .clk_in(clk_in),
        .RST(RST),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .ctrl_in(ctrl_in),
        .data(data),
        .addr(addr),
        .wr_ready(wr_ready),
        .en_out(en_out),
        .data_out(data_out),
        .addr_out(addr_out),
        .hz_addr(hz_addr),
        .hz_pending(hz_pending),
        .hz_data(hz_data),
        .wr_count(wr_count)
    );

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [31:0] d;
        logic [3:0]  a;
        logic        wr;
        logic [3:0]  hz;
        logic        e_rdy;
        logic        e_en;
        logic [31:0] e_d;
        logic [3:0]  e_a;
        logic        e_hp;
        logic [31:0] e_hd;
        logic [15:0] e_wc;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [31:0] d,
                                input logic [3:0] a, input logic wr, input logic [3:0] hz,
                                input logic e_rdy, input logic e_en, input logic [31:0] e_d,
                                input logic [3:0] e_a, input logic e_hp, input logic [31:0] e_hd,
                                input logic [15:0] e_wc);
        vec_t r;
        r.v = v; r.op = op; r.d = d; r.a = a; r.wr = wr; r.hz = hz;
        r.e_rdy = e_rdy; r.e_en = e_en; r.e_d = e_d; r.e_a = e_a;
        r.e_hp = e_hp; r.e_hd = e_hd; r.e_wc = e_wc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] d,
                         input logic [3:0] a, input logic wr, input logic [3:0] hz);
        in_valid = v; ctrl_in = op; data = d; addr = a; wr_ready = wr; hz_addr = hz;
    endtask

    initial begin
        tbl[0]  = mk(0, NOP, 0,   0, 1, 0,  1, 0, 0,   0, 0, 0, 0);
        tbl[1]  = mk(1, ADD, 32'hFFFF_FFFB, 3, 1, 3,  1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, NOP, 0,   0, 1, 3,  1, 1, 32'hFFFF_FFFB, 3, 1, 32'hFFFF_FFFB, 0);
        tbl[3]  = mk(0, NOP, 0,   0, 1, 3,  1, 0, 0,   0, 0, 0, 1);
        tbl[4]  = mk(1, ADD, 11,  0, 1, 0,  1, 0, 0,   0, 0, 0, 1);
        tbl[5]  = mk(1, BEQ, 12,  2, 1, 2,  1, 0, 0,   0, 0, 0, 1);
        tbl[6]  = mk(0, NOP, 0,   0, 1, 2,  1, 0, 0,   0, 0, 0, 1);
        tbl[7]  = mk(1, SUB, 7,   5, 0, 5,  1, 0, 0,   0, 0, 0, 1);
        tbl[8]  = mk(1, MUL, 9,   5, 0, 5,  1, 1, 7,   5, 1, 7, 1);
        tbl[9]  = mk(0, NOP, 0,   0, 0, 5,  1, 1, 7,   5, 1, 9, 1);
        tbl[10] = mk(0, NOP, 0,   0, 0, 6,  1, 1, 7,   5, 0, 0, 1);
        tbl[11] = mk(0, NOP, 0,   0, 1, 5,  1, 1, 7,   5, 1, 9, 1);
        tbl[12] = mk(0, NOP, 0,   0, 1, 5,  1, 1, 9,   5, 1, 9, 2);
        tbl[13] = mk(0, NOP, 0,   0, 0, 5,  1, 0, 0,   0, 0, 0, 3);
        tbl[14] = mk(1, LW,  100, 1, 0, 1,  1, 0, 0,   0, 0, 0, 3);
        tbl[15] = mk(1, AND, 200, 2, 0, 1,  1, 1, 100, 1, 1, 100, 3);
        tbl[16] = mk(1, OR,  300, 3, 0, 2,  1, 1, 100, 1, 1, 200, 3);
        tbl[17] = mk(1, NOT, 400, 4, 0, 3,  1, 1, 100, 1, 1, 300, 3);
        tbl[18] = mk(1, DIV, 500, 6, 0, 4,  0, 1, 100, 1, 1, 400, 3);
        tbl[19] = mk(1, DIV, 600, 7, 1, 6,  0, 1, 100, 1, 0, 0, 3);
        tbl[20] = mk(0, NOP, 0,   0, 0, 1,  1, 1, 200, 2, 0, 0, 4);
        tbl[21] = mk(0, NOP, 0,   0, 1, 7,  1, 1, 200, 2, 0, 0, 4);
        tbl[22] = mk(0, NOP, 0,   0, 1, 4,  1, 1, 300, 3, 1, 400, 5);
        tbl[23] = mk(0, NOP, 0,   0, 1, 4,  1, 1, 400, 4, 1, 400, 6);
        tbl[24] = mk(0, NOP, 0,   0, 1, 7,  1, 0, 0,   0, 0, 0, 7);
        tbl[25] = mk(1, ADD, 1,   9, 1, 9,  1, 0, 0,   0, 0, 0, 7);
        tbl[26] = mk(1, SUB, 2,  10, 1, 9,  1, 1, 1,   9, 1, 1, 7);
        tbl[27] = mk(0, NOP, 0,   0, 1, 10, 1, 1, 2,  10, 1, 2, 8);
        tbl[28] = mk(0, NOP, 0,   0, 1, 10, 1, 0, 0,   0, 0, 0, 9);

        RST = 1'b0;
        drive(0, NOP, 0, 0, 1, 0);
        #2;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_en_out", 32'(en_out), 0);
        chk("rst_wr_count", 32'(wr_count), 0);
        repeat (2) @(negedge clk_in);
        RST = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk_in);
            drive(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].a, tbl[i].wr, tbl[i].hz);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_en_out", i), 32'(en_out), 32'(tbl[i].e_en));
            chk($sformatf("v%0d_data_out", i), data_out, tbl[i].e_d);
            chk($sformatf("v%0d_addr_out", i), 32'(addr_out), 32'(tbl[i].e_a));
            chk($sformatf("v%0d_hz_pending", i), 32'(hz_pending), 32'(tbl[i].e_hp));
            chk($sformatf("v%0d_hz_data", i), hz_data, tbl[i].e_hd);
            chk($sformatf("v%0d_wr_count", i), 32'(wr_count), 32'(tbl[i].e_wc));
        end

        // Reset with three writes buffered and the register file ready
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_in);
            drive(1, LW, 32'(i * 11), 4'(i), 0, 1);
        end
        @(negedge clk_in);
        drive(0, NOP, 0, 0, 1, 1);
        #1;
        chk("pre_rst_en_out", 32'(en_out), 1);
        chk("pre_rst_data_out", data_out, 11);
        chk("pre_rst_hz_pending", 32'(hz_pending), 1);
        chk("pre_rst_wr_count", 32'(wr_count), 9);
        #1;
        RST = 1'b0;
        #1;
        chk("mid_rst_en_out", 32'(en_out), 0);
        chk("mid_rst_data_out", data_out, 0);
        chk("mid_rst_addr_out", 32'(addr_out), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        chk("mid_rst_hz_pending", 32'(hz_pending), 0);
        chk("mid_rst_hz_data", hz_data, 0);
        chk("mid_rst_wr_count", 32'(wr_count), 0);
        repeat (2) @(negedge clk_in);
        RST = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_en_out", 32'(en_out), 0);
        repeat (2) @(negedge clk_in);
        #1;
        chk("post_rst_en_out_late", 32'(en_out), 0);
        chk("post_rst_wr_count", 32'(wr_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
